button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Collects press events from N button-classifier channels. Each channel reports one event code per release: 1 = short press, 2 = long press.
- Holds one pending event per channel and grants channels round-robin onto a single registered event output with a valid/ready handshake.
- Sits between the per-button press classifiers and the mode/control logic that consumes one event at a time.
- Counts and flags events lost when a channel overruns.

Parameters:
- N, 4, number of requester channels (2..8).
- CW, 2, event code width.
- DROP_W, 8, drop counter width; the counter saturates.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- ev_valid  in  N  per-channel single-cycle event strobe
- ev_code  in  N*CW  per-channel code; channel i uses bits [i*CW +: CW]; valid codes are 1 and 2
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high
- out_ch  out  3  granted channel index
- out_code  out  CW  granted event code
- pend  out  N  per-channel pending flags
- overflow  out  N  sticky per-channel overrun flags
- drop_cnt  out  DROP_W  total dropped events, saturating
- clr  in  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (reset = 0, asynchronous):
  - pend, overflow and drop_cnt go to 0.
  - out_valid = 0, out_ch = 0, out_code = 0.
  - Round-robin pointer = 0.
  - Any in-flight output is discarded.
- Capture, channel i, on a clk edge with ev_valid[i] = 1:
  - Code 0 or 3: ignored. No pend change, no count.
  - pend[i] = 0: slot <= code, pend[i] <= 1.
  - pend[i] = 1, new code 2 and held code 1: slot is overwritten with 2 (long supersedes short). The short press counts as dropped.
  - pend[i] = 1, any other case: the new event is dropped and the held event is kept.
  - Every drop sets overflow[i] and increments drop_cnt by 1, saturating at all-ones.
  - Several channels dropping in the same cycle add the number of drops.
- Arbitration state machine, states IDLE and HOLD:
  - IDLE: if any pend bit is set, pick the first pending channel at or after the pointer, wrapping modulo N.
    - Load out_ch and out_code, set out_valid, clear that pend bit, move the pointer to grant+1 mod N, go to HOLD.
    - All of this happens in one edge.
  - HOLD: out_ch and out_code stay stable.
    - out_ready = 1: the transfer completes. If another channel is pending, it is granted on the same edge (back-to-back, out_valid stays 1). Otherwise out_valid <= 0 and the state returns to IDLE.
    - out_ready = 0: stay in HOLD; out_valid must not drop.
- Latency: ev_valid at edge k sets pend at k. The earliest out_valid is after edge k+1 when the arbiter is idle.
- Same-channel events:
  - A granted channel's slot is free once granted, so a new event on that channel at the grant edge is captured into pend.
  - Capture takes priority over the clear of that pend bit.
- Fairness: a channel that is continuously pending waits at most N−1 grants.
- clr takes precedence over a drop in the same cycle. After clr, overflow = 0 and drop_cnt = 0.
- out_ready while out_valid = 0 has no effect.

Decomposition:
- Package btn_pkg:
  - Event code constants EV_NONE = 0, EV_SHORT = 1, EV_LONG = 2.
  - Arbiter state encoding.
  - Function next_rr(pend, ptr) returning the grant index.
- One sub-module, rr_pick: combinational round-robin priority encoder with inputs req[N] and ptr, outputs gnt_idx and gnt_any. It is reusable by other shared-resource controllers.

Test Plan:
- Single event: ch2 short (code 1), out_ready = 1 → out_valid high one cycle later with out_ch = 2, out_code = 1, then low. pend = 0, drop_cnt = 0.
- Simultaneous: ch0, ch1 and ch3 events in the same cycle, pointer = 0, out_ready held 1 → grants 0, 1, 3 on consecutive cycles, out_valid continuously high for 3 cycles, then pointer = 0 (grant 3 + 1 mod 4).
- Backpressure: ch1 long with out_ready = 0 for 10 cycles → out_valid stays 1 with stable out_ch = 1, out_code = 2. Transfer occurs on the first cycle out_ready = 1.
- Overrun: ch0 short pending under backpressure, then ch0 short again → drop_cnt = 1, overflow[0] = 1, held code 1. A further ch0 long → slot becomes 2, drop_cnt = 2.
- Saturation and clear: 300 forced drops with DROP_W = 8 → drop_cnt = 255. Then clr → drop_cnt = 0 and overflow = 0, and a drop in the clr cycle is not counted.
- Reset mid-transfer: assert reset asynchronously during HOLD, between clock edges → out_valid and pend are 0 immediately. After release, the first event on ch3 grants ch3 with the pointer starting at 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button event path: event codes, arbiter state
// encoding and the round-robin search used by the grant logic.
package btn_pkg;

  localparam int EV_NONE  = 0;
  localparam int EV_SHORT = 1;
  localparam int EV_LONG  = 2;

  // Widest requester vector the round-robin search supports.
  localparam int MAX_CH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // First set bit of pend at or after ptr, wrapping modulo n; returns ptr if none.
  function automatic logic [2:0] next_rr(input logic [MAX_CH-1:0] pend,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [3:0] idx;
    logic       found;
    next_rr = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (!found && (k < n) && pend[idx[2:0]]) begin
        next_rr = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: picks the first requester at
// or after ptr, wrapping modulo N.
module rr_pick
  import btn_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   gnt_idx,
  output logic         gnt_any
);

  assign gnt_idx = next_rr(8'(req), ptr, N);
  assign gnt_any = |req;

endmodule

// File: rtl/button_event_arbiter.sv
// Holds one pending press event per button channel and hands them one at a
// time, round-robin, to a registered valid/ready output; counts overruns.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N      = 4,
  parameter int CW     = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      ev_valid,
  input  logic [N*CW-1:0]   ev_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_ch,
  output logic [CW-1:0]     out_code,
  output logic [N-1:0]      pend,
  output logic [N-1:0]      overflow,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr
);

  localparam int SUM_W = DROP_W + 4;

  arb_state_t          state_reg, state_next;
  logic [2:0]          ptr_reg;
  logic [N-1:0]        pend_reg, pend_next;
  logic [N-1:0]        overflow_reg;
  logic [DROP_W-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]       slot_reg [N];
  logic [2:0]          out_ch_reg;
  logic [CW-1:0]       out_code_reg;

  logic [2:0]          gnt_idx;
  logic                gnt_any;
  logic                grant_en;
  logic                valid_int;
  logic [CW-1:0]       gnt_code;
  logic [N-1:0]        gnt_onehot;
  logic [N-1:0]        cap_load;
  logic [N-1:0]        cap_drop;
  logic [SUM_W-1:0]    drop_sum;
  logic [SUM_W-1:0]    drop_total;

  rr_pick #(.N(N)) u_pick (
    .req     (pend_reg),
    .ptr     (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (gnt_any) state_next = ST_HOLD;
      ST_HOLD: if (out_ready && !gnt_any) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A grant is taken when idle, or back-to-back on the edge that completes a transfer.
  always_comb begin
    grant_en  = 1'b0;
    valid_int = 1'b0;
    case (state_reg)
      ST_IDLE: grant_en = gnt_any;
      ST_HOLD: begin
        valid_int = 1'b1;
        grant_en  = out_ready && gnt_any;
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [CW-1:0] code;
      logic          code_ok;
      logic          free;

      assign gnt_onehot[gi] = grant_en && (gnt_idx == 3'(gi));
      assign code    = ev_code[gi*CW +: CW];
      assign code_ok = ev_valid[gi] && ((code == CW'(EV_SHORT)) || (code == CW'(EV_LONG)));
      // The slot being granted this edge is free for a new event on the same edge.
      assign free    = !pend_reg[gi] || gnt_onehot[gi];
      assign cap_load[gi] = code_ok && (free ||
                            ((code == CW'(EV_LONG)) && (slot_reg[gi] == CW'(EV_SHORT))));
      assign cap_drop[gi] = code_ok && !free;
    end
  endgenerate

  assign pend_next = cap_load | (pend_reg & ~gnt_onehot);

  always_comb begin
    gnt_code = '0;
    for (int i = 0; i < N; i++)
      if (gnt_idx == 3'(i)) gnt_code = slot_reg[i];
  end

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < N; i++)
      drop_sum = drop_sum + SUM_W'(cap_drop[i]);
    drop_total = {4'b0, drop_cnt_reg} + drop_sum;
    if (clr)
      drop_cnt_next = '0;
    else if (drop_total > {4'b0, {DROP_W{1'b1}}})
      drop_cnt_next = '1;
    else
      drop_cnt_next = drop_total[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) slot_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (cap_load[i]) slot_reg[i] <= ev_code[i*CW +: CW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg      <= '0;
      pend_reg     <= '0;
      overflow_reg <= '0;
      drop_cnt_reg <= '0;
      out_ch_reg   <= '0;
      out_code_reg <= CW'(EV_NONE);
    end else begin
      pend_reg     <= pend_next;
      overflow_reg <= clr ? '0 : (overflow_reg | cap_drop);
      drop_cnt_reg <= drop_cnt_next;
      if (grant_en) begin
        out_ch_reg   <= gnt_idx;
        out_code_reg <= gnt_code;
        ptr_reg      <= (gnt_idx == 3'(N-1)) ? 3'd0 : gnt_idx + 3'd1;
      end
    end
  end

  assign out_valid = valid_int;
  assign out_ch    = out_ch_reg;
  assign out_code  = out_code_reg;
  assign pend      = pend_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected grants are queued as
// events are driven and compared whenever a transfer is seen on the output.
`timescale 1ns/1ps
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int CW = 2;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [2:0]    ch;
    logic [CW-1:0] code;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [N-1:0]      ev_valid;
  logic [N*CW-1:0]   ev_code;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_ch;
  logic [CW-1:0]     out_code;
  logic [N-1:0]      pend;
  logic [N-1:0]      overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              clr;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  button_event_arbiter #(.N(N), .CW(CW), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_code  (out_code),
    .pend      (pend),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Transfers complete on the next rising edge; sample them half a cycle early.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_xfer", {29'd0, out_ch}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("xfer_ch", 32'(out_ch), 32'(e.ch));
        check_eq("xfer_code", 32'(out_code), 32'(e.code));
      end
    end
  end

  task automatic push(input int ch, input int code);
    exp_t e;
    e.ch   = 3'(ch);
    e.code = CW'(code);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*CW-1:0] codes);
    ev_valid = v;
    ev_code  = codes;
    @(posedge clk);
    #1;
    ev_valid = '0;
    ev_code  = '0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    ev_valid  = '0;
    ev_code   = '0;
    out_ready = 1'b0;
    clr       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_pend", 32'(pend), 32'd0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_ch", 32'(out_ch), 32'd0);
    check_eq("rst_code", 32'(out_code), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single event, ch2 short
    out_ready = 1'b1;
    push(2, 1);
    drive(4'b0100, 8'h10);
    @(negedge clk);
    check_eq("single_pend", 32'(pend), 32'h4);
    check_eq("single_nolatch", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("single_done", 32'(out_valid), 32'd0);
    check_eq("single_pend0", 32'(pend), 32'd0);
    check_eq("single_drop", 32'(drop_cnt), 32'd0);

    // ch3 moves the pointer back to 0
    push(3, 1);
    drive(4'b1000, 8'h40);
    wait_drain(10);

    // simultaneous ch0, ch1, ch3
    push(0, 1); push(1, 1); push(3, 1);
    drive(4'b1011, 8'h45);
    @(negedge clk);
    check_eq("simul_pend", 32'(pend), 32'hB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("simul_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check_eq("simul_end", 32'(out_valid), 32'd0);

    // backpressure, ch1 long
    out_ready = 1'b0;
    push(1, 2);
    drive(4'b0010, 8'h08);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_ch", 32'(out_ch), 32'd1);
      check_eq("bp_code", 32'(out_code), 32'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_released", 32'(out_valid), 32'd0);
    check_eq("bp_q", 32'(exp_q.size()), 32'd0);

    // overrun on ch0 while ch2 holds the output
    out_ready = 1'b0;
    push(2, 1); push(0, 2);
    drive(4'b0100, 8'h10);
    drive(4'b0001, 8'h01);
    drive(4'b0001, 8'h01);
    check_eq("ovr_drop1", 32'(drop_cnt), 32'd1);
    check_eq("ovr_flag", 32'(overflow), 32'h1);
    drive(4'b0001, 8'h02);
    check_eq("ovr_drop2", 32'(drop_cnt), 32'd2);
    check_eq("ovr_pend", 32'(pend), 32'h1);
    check_eq("ovr_hold_ch", 32'(out_ch), 32'd2);
    out_ready = 1'b1;
    wait_drain(10);
    check_eq("ovr_idle", 32'(out_valid), 32'd0);

    // codes 0 and 3 are ignored
    drive(4'b0001, 8'h03);
    drive(4'b0010, 8'h00);
    @(negedge clk);
    check_eq("ign_pend", 32'(pend), 32'd0);
    check_eq("ign_drop", 32'(drop_cnt), 32'd2);
    check_eq("ign_valid", 32'(out_valid), 32'd0);

    // clear, simultaneous drops, saturation, clear beats a drop
    out_ready = 1'b0;
    clr = 1'b1;
    drive('0, '0);
    clr = 1'b0;
    check_eq("clr_drop", 32'(drop_cnt), 32'd0);
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    push(3, 1); push(1, 1); push(2, 1);
    drive(4'b1000, 8'h40);
    drive(4'b0110, 8'h14);
    drive(4'b0110, 8'h14);
    check_eq("dual_drop", 32'(drop_cnt), 32'd2);
    check_eq("dual_ovf", 32'(overflow), 32'h6);
    for (int i = 0; i < 300; i++) drive(4'b0010, 8'h04);
    check_eq("sat_drop", 32'(drop_cnt), 32'd255);
    clr = 1'b1;
    drive(4'b0010, 8'h04);
    clr = 1'b0;
    check_eq("clr_win_drop", 32'(drop_cnt), 32'd0);
    check_eq("clr_win_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    check_eq("clr_after", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1;
    wait_drain(20);

    // asynchronous reset while holding a grant; pointer was 3 before it
    out_ready = 1'b0;
    drive(4'b0100, 8'h10);
    drive(4'b0010, 8'h04);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_pend", 32'(pend), 32'd0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(0, 1); push(3, 1);
    drive(4'b1001, 8'h41);
    wait_drain(10);
    push(3, 1);
    drive(4'b1000, 8'h40);
    wait_drain(10);
    @(posedge clk);
    #1;
    check_eq("final_valid", 32'(out_valid), 32'd0);
    check_eq("final_q", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
